// File: rtl/sram_like_if.sv
// sram_like_if: initiator/responder handshake bundle for the sram-like bus.
// The initiator drives req/wr/size/wstrb/addr/wdata.
// The responder answers with addr_ok/data_ok/rdata.
interface sram_like_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_resp.sv
// sram_like_resp: sram-like responder in front of a 1-cycle-latency synchronous RAM.
// Accepts up to DEPTH outstanding requests and returns one in-order data_ok for each.
// The optional macro RESP_DELAY_EN adds an LFSR gate that randomly withholds data_ok.
module sram_like_resp #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  sram_like_if.slave            bus,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);

  // count covers the in-flight stage plus FIFO entries
  logic [CW-1:0] count_q, count_d;
  logic          inflight_valid_q, inflight_wr_q;
  logic [31:0]   fifo_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;

  logic          accept, addr_ok, data_ok, gate, fifo_nonempty;
  logic [CW-1:0] fifo_cnt;
  logic [31:0]   push_data;

  // size and the untranslated address bits carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{bus.size, bus.addr[31:ADDR_WIDTH+2], bus.addr[1:0]};

`ifdef RESP_DELAY_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11; steps every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign gate = (lfsr_q[1:0] != 2'b00);
`else
  assign gate = 1'b1;
`endif

  // Handshake, occupancy and RAM drive
  always_comb begin
    fifo_cnt      = count_q - CW'(inflight_valid_q);
    fifo_nonempty = (fifo_cnt != '0);
    data_ok       = fifo_nonempty & gate;
    // a pop this cycle frees a slot for a same-cycle accept
    addr_ok       = !reset & ((count_q < DepthC) | data_ok);
    accept        = bus.req & addr_ok;
    count_d       = count_q + CW'(accept) - CW'(data_ok);
    push_data     = inflight_wr_q ? 32'b0 : ram_rdata;
    ram_en        = accept;
    ram_we        = (accept & bus.wr) ? bus.wstrb : 4'b0;
    ram_addr      = bus.addr[ADDR_WIDTH+1:2];
    ram_wdata     = bus.wdata;
  end

  assign bus.addr_ok = addr_ok;
  assign bus.data_ok = data_ok;
  assign bus.rdata   = data_ok ? fifo_q[rptr_q] : 32'b0;

  // Occupancy counter and in-flight stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q          <= '0;
      inflight_valid_q <= 1'b0;
      inflight_wr_q    <= 1'b0;
    end else begin
      count_q          <= count_d;
      inflight_valid_q <= accept;
      inflight_wr_q    <= accept & bus.wr;
    end
  end

  // Response FIFO: push from in-flight stage, pop on data_ok
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_q[i] <= 32'b0;
      end
    end else begin
      if (inflight_valid_q) begin
        fifo_q[wptr_q] <= push_data;
        wptr_q         <= (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
      end
      if (data_ok) begin
        rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
      end
    end
  end

endmodule

// File: doc/sram_like_resp.md
Name: sram_like_resp

Overview:
- Responder (slave) end of the team's sram-like interface: req/wr/size/wstrb/addr/wdata out from the initiator; addr_ok/data_ok/rdata back.
- Fronts a single-port synchronous RAM with 1-cycle read latency.
- Accepts up to DEPTH outstanding requests and returns exactly one data_ok per accepted request, strictly in order, for reads and writes alike.
- Used as the instruction/data memory model behind the fetch stage and as the on-chip scratchpad slave.

Parameters:
- ADDR_WIDTH, 12, word-address bits of the backing RAM (RAM holds 2^ADDR_WIDTH 32-bit words).
- DEPTH, 2, maximum accepted-but-unanswered requests (>=1); equals the response FIFO depth.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  initiator request valid.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0 = byte, 1 = half, 2 = word; not checked, byte lanes come from wstrb.
- wstrb  in  4  write byte enables.
- addr  in  32  byte address; bits [ADDR_WIDTH+1:2] index the RAM, other bits ignored.
- wdata  in  32  write data.
- addr_ok  out  1  request accepted this cycle when req & addr_ok.
- data_ok  out  1  head response delivered this cycle; no backpressure.
- rdata  out  32  read data, valid with data_ok; 0 for write responses.
- ram_en  out  1  RAM access enable.
- ram_we  out  4  RAM byte write enables.
- ram_addr  out  ADDR_WIDTH  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid the cycle after ram_en with ram_we==0.

Behaviour:
- Reset values: addr_ok=0 while reset is high, data_ok=0, rdata=0, count=0, FIFO empty, in-flight stage empty.
- Reset mid-operation drops every outstanding request; no data_ok is ever issued for them.
- accept = req & addr_ok.
- addr_ok = !reset & ((count < DEPTH) | data_ok). A pop in the same cycle frees a slot; the data_ok-to-addr_ok path is combinational from registered state.
- count: width $clog2(DEPTH+1). count_next = count + accept - data_ok. It covers in-flight plus FIFO entries and never exceeds DEPTH.
- RAM drive, combinational in the accept cycle:
  - ram_en = accept.
  - ram_we = (accept & wr) ? wstrb : 4'b0.
  - ram_addr = addr[ADDR_WIDTH+1:2].
  - ram_wdata = wdata.
- In-flight stage: registers {valid, wr} on accept; cleared otherwise.
- FIFO push, next cycle: when the in-flight stage is valid, push {wr ? 32'b0 : ram_rdata}. The FIFO is DEPTH entries, circular read/write pointers, wrap modulo DEPTH.
- Push and pop in the same cycle are both performed. Push into a full FIFO cannot occur because count is bounded.
- data_ok is asserted while the FIFO is non-empty and the delay gate (Optional Feature) is open. rdata = head entry when data_ok, else 0. Pop on data_ok.
- Latency: accept in cycle N, RAM read during N+1, data_ok earliest in N+2.
- Throughput: 1 request/cycle sustained when DEPTH>=2 and no delay. DEPTH=1 gives 1 request per 2 cycles.
- Ordering: responses strictly in acceptance order; reads and writes interleave freely.
- Read-after-write to the same word in consecutive accepts returns the new data (RAM write completes at the accept edge).
- req deasserted or changing while addr_ok=0 is legal; nothing is latched without accept.

Optional Feature:
- RESP_DELAY_EN defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset, steps every cycle.
  - data_ok is suppressed in any cycle where lfsr[1:0]==2'b00, even with the FIFO non-empty. The FIFO then fills and addr_ok drops when count==DEPTH.
  - Purpose: stress the initiator's stall and discard logic.
- RESP_DELAY_EN undefined: no LFSR; the gate is always open.

Test Plan:
- Preload RAM[0x10]=0x1234_5678; read addr 0x40 with req held 1 cycle -> addr_ok=1 cycle 0, ram_en=1 ram_addr=0x10; data_ok=1 rdata=0x1234_5678 in cycle 2.
- Write addr 0x44 wstrb=4'b0011 wdata=0xAABB_CCDD over RAM 0xFFFF_FFFF, then read 0x44 next cycle -> write data_ok rdata=0; read returns 0xFFFF_CCDD.
- Back-to-back reads 0x0, 0x4, 0x8, 0xC with req held, DEPTH=2, no delay -> addr_ok every cycle, four data_ok in consecutive cycles 2..5 in order.
- DEPTH=1: req held for reads 0x0 and 0x4 -> addr_ok pattern 1,0,1; count never exceeds 1.
- RESP_DELAY_EN, DEPTH=2: req held for 20 reads -> count<=2 always, exactly 20 data_ok, rdata order matches addresses, addr_ok=0 whenever count==2 and data_ok=0.
- Accept 2 reads, assert reset asynchronously mid-cycle for 1 cycle -> data_ok stays 0 and addr_ok=0 while reset is high; a new read after reset returns the correct data in 2 cycles.
